// File: rtl/mu0_cpu.sv
// MU0 accumulator core: two-cycle FETCH/EXEC sequencer driving the MU0 memory bus.
// Define MU0_CYCLE_CNT_EN to build the saturating executed-cycle counter on cycle_cnt.
module mu0_cpu #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] addr,
    inout  wire  [15:0] data,
    output logic        MEMrq,
    output logic        RnW,
    output logic        STP_flag,
    output logic [15:0] cycle_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    state_t      state_reg, state_next;
    logic [11:0] pc_reg, pc_next;
    logic [15:0] ir_reg, ir_next;
    logic [15:0] acc_reg, acc_next;
    logic        drive_en;

    wire [3:0]  opcode  = ir_reg[15:12];
    wire [11:0] operand = ir_reg[11:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
            ir_reg    <= 16'h0000;
            acc_reg   <= 16'h0000;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            acc_reg   <= acc_next;
        end
    end

    // Bus outputs depend only on state/PC/IR; data feeds register next-values only.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        acc_next   = acc_reg;
        addr       = operand;
        MEMrq      = 1'b0;
        RnW        = 1'b1;
        STP_flag   = 1'b0;
        drive_en   = 1'b0;
        case (state_reg)
            FETCH: begin
                addr       = pc_reg;
                MEMrq      = 1'b1;
                ir_next    = data;
                pc_next    = pc_reg + 12'd1;
                state_next = EXEC;
            end
            EXEC: begin
                state_next = FETCH;
                case (opcode)
                    OP_LDA: begin
                        MEMrq    = 1'b1;
                        acc_next = data;
                    end
                    OP_STO: begin
                        MEMrq    = 1'b1;
                        RnW      = 1'b0;
                        drive_en = 1'b1;
                    end
                    OP_ADD: begin
                        MEMrq    = 1'b1;
                        acc_next = acc_reg + data;
                    end
                    OP_SUB: begin
                        MEMrq    = 1'b1;
                        acc_next = acc_reg - data;
                    end
                    OP_JMP: pc_next = operand;
                    OP_JGE: if (!acc_reg[15]) pc_next = operand;
                    OP_JNE: if (acc_reg != 16'h0000) pc_next = operand;
                    OP_STP: state_next = HALT;
                    default: ;
                endcase
            end
            HALT: begin
                addr     = pc_reg;
                STP_flag = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    assign data = drive_en ? acc_reg : 16'hzzzz;

`ifdef MU0_CYCLE_CNT_EN
    logic [15:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_reg <= 16'h0000;
        else if (state_reg != HALT && cnt_reg != 16'hFFFF)
            cnt_reg <= cnt_reg + 16'd1;
    end

    assign cycle_cnt = cnt_reg;
`else
    assign cycle_cnt = 16'h0000;
`endif

endmodule
